// File: rtl/spi_ram_master.sv
// spi_ram_master: SPI mode-0 master that streams a 32x24 RAM through a slave.
// Define SPI_MASTER_LOOP_EN to wrap the address and keep running forever.
module spi_ram_master_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

  // Synchronous write, registered read (one cycle latency)
  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end
endmodule

module spi_ram_master #(
  parameter int CLK_DIV     = 4,
  parameter int DATA_W      = 24,
  parameter int ADDR_W      = 5,
  parameter int START_DELAY = 16,
  parameter int GAP         = 4
) (
  input  logic clk,
  input  logic rstn,
  output logic sck,
  output logic csn,
  output logic mo,
  input  logic mi
);
  localparam int HALF  = CLK_DIV / 2;
  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int CNT_W = 16;
  // WB and LOAD also hold csn high, so the GAP state covers the rest
  localparam int GAP_CYC = (GAP > 2) ? GAP - 2 : 1;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_XFER, S_WB, S_GAP, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PH_W-1:0]   r_ph;
  logic [BIT_W-1:0]  r_bit;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_shreg;
  logic              r_rx;
  logic              r_sck;
  logic              r_csn;
  logic [DATA_W-1:0] w_rdata;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_we;
  logic              w_ph_rise;
  logic              w_ph_last;
  logic              w_bit_last;
  logic              w_idle_end;
  logic              w_gap_end;

  assign w_ph_rise  = (r_ph == PH_W'(HALF - 1));
  assign w_ph_last  = (r_ph == PH_W'(CLK_DIV - 1));
  assign w_bit_last = (r_bit == BIT_W'(DATA_W - 1));
  assign w_idle_end = (r_cnt == CNT_W'(START_DELAY - 1));
  assign w_gap_end  = (r_cnt == CNT_W'(GAP_CYC - 1));
  assign w_we       = (r_state == S_WB);
  // Look ahead during WB so LOAD sees the next word
  assign w_raddr    = w_we ? r_addr + 1'b1 : r_addr;

  assign sck = r_sck;
  assign csn = r_csn;
  assign mo  = ~r_csn & r_shreg[DATA_W-1];

  spi_ram_master_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) ram_inst (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(r_addr),
    .i_wdata(r_shreg),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_idle_end) w_next = S_LOAD;
      S_LOAD: w_next = S_XFER;
      S_XFER: if (w_ph_last && w_bit_last) w_next = S_WB;
      S_WB: begin
`ifdef SPI_MASTER_LOOP_EN
        w_next = (GAP > 2) ? S_GAP : S_LOAD;
`else
        if (r_addr == LAST) w_next = S_DONE;
        else w_next = (GAP > 2) ? S_GAP : S_LOAD;
`endif
      end
      S_GAP:  if (w_gap_end) w_next = S_LOAD;
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: counters, shifter, sck/csn generation, address
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ph    <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_shreg <= '0;
      r_rx    <= 1'b0;
      r_sck   <= 1'b0;
      r_csn   <= 1'b1;
    end else begin
      r_csn <= (w_next != S_XFER);
      if (w_next != r_state) r_cnt <= '0;
      else if (r_state == S_IDLE || r_state == S_GAP)
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_LOAD) r_shreg <= w_rdata;
      if (r_state == S_XFER) begin
        r_ph <= w_ph_last ? '0 : r_ph + 1'b1;
        if (w_ph_rise) begin
          r_sck <= 1'b1;
          r_rx  <= mi;
        end
        if (w_ph_last) begin
          r_sck   <= 1'b0;
          r_shreg <= {r_shreg[DATA_W-2:0], r_rx};
          r_bit   <= w_bit_last ? '0 : r_bit + 1'b1;
        end
      end
      if (r_state == S_WB) r_addr <= r_addr + 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: scoreboard bench with a mode-0 slave model.
// Expected tx/rx words queue at frame start and retire at csn rise.
module tb_spi_ram_master;
  localparam int CLK_DIV     = 4;
  localparam int DATA_W      = 24;
  localparam int ADDR_W      = 5;
  localparam int START_DELAY = 16;
  localparam int GAP         = 4;
  localparam int HALF        = CLK_DIV / 2;
  localparam int DEPTH       = 1 << ADDR_W;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic mi   = 1'b0;
  logic sck, csn, mo;

  spi_ram_master #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .START_DELAY(START_DELAY), .GAP(GAP)
  ) dut (
    .clk(clk), .rstn(rstn), .sck(sck),
    .csn(csn), .mo(mo), .mi(mi)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] q_tx [$];
  logic [DATA_W-1:0] q_wb [$];
  logic [DATA_W-1:0] rx0, rx_cur, txcap, saved, last_tx;
  int fidx = 0, faddr = 0, wb_addr = 0;
  int nrise = 0, lowcnt = 0, gapcnt = 0, run = 0;
  int nframes = 0, nfr_att = 0, nwb = 0;
  bit in_frame = 0, psck = 0, tmg_bad = 0;
  bit idle_bad = 0, wb_pend = 0;

  // Slave model and bus monitor, sampled on the falling clk edge
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      if (in_frame) begin
        void'(q_tx.pop_back());
        void'(q_wb.pop_back());
        model[faddr] = saved;
      end
      if (wb_pend) void'(q_wb.pop_front());
      in_frame = 0; wb_pend = 0; fidx = 0;
      psck = 0; gapcnt = 0; nrise = 0;
      nfr_att = 0; mi = 1'b0;
    end else begin
      if (!csn) begin
        if (!in_frame) begin
          if (nfr_att > 0) check("gap_len", 32'(gapcnt), 32'(GAP));
          in_frame = 1; nrise = 0; lowcnt = 0;
          run = 0; tmg_bad = 0; txcap = '0;
          faddr = fidx;
          saved = model[faddr];
          rx_cur = (faddr == 0) ? rx0 : DATA_W'($urandom);
          q_tx.push_back(model[faddr]);
          q_wb.push_back(rx_cur);
          model[faddr] = rx_cur;
          mi = rx_cur[DATA_W-1];
        end
        lowcnt++;
        if (sck == psck) run++;
        else begin
          if (run != HALF) tmg_bad = 1;
          run = 1;
        end
        if (sck && !psck) begin
          nrise++;
          txcap = {txcap[DATA_W-2:0], mo};
        end
        if (!sck && psck && nrise < DATA_W)
          mi = rx_cur[DATA_W-1-nrise];
      end else begin
        if (in_frame) begin
          in_frame = 0;
          if (run != HALF || !psck || sck) tmg_bad = 1;
          check("frame_len", 32'(lowcnt), 32'(DATA_W * CLK_DIV));
          check("sck_rises", 32'(nrise), 32'(DATA_W));
          check("sck_timing", 32'(tmg_bad), 32'd0);
          check("mo_word", 32'(txcap), 32'(q_tx.pop_front()));
          last_tx = txcap;
          nframes++; nfr_att++;
          wb_pend = 1; wb_addr = faddr; gapcnt = 0;
          fidx = (fidx + 1) % DEPTH;
          mi = 1'b0;
        end
        gapcnt++;
        if (mo) idle_bad = 1;
        if (wb_pend && gapcnt == 2) begin
          wb_pend = 0;
          check("wb_word", 32'(dut.ram_inst.mem[wb_addr]),
                32'(q_wb.pop_front()));
          nwb++;
        end
      end
      psck = sck;
    end
  end

  task automatic wait_wb(input int target, input int budget,
                         input string tag);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (nwb >= target) break;
    end
    check(tag, 32'(nwb >= target), 32'd1);
  endtask

  int base_wb, base_fr;
  bit hit;

  initial begin
    rx0  = '0;
    rstn = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = DATA_W'($urandom);
    model[0] = 24'hABCDEF;
    for (int i = 0; i < DEPTH; i++) dut.ram_inst.mem[i] = model[i];
    repeat (3) @(negedge clk);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_csn", 32'(csn), 32'd1);
    check("rst_mo", 32'(mo), 32'd0);
    rstn = 1'b1;
    repeat (START_DELAY) @(posedge clk);
    #1;
    check("idle_csn", 32'(csn), 32'd1);
    check("idle_sck", 32'(sck), 32'd0);
    @(posedge clk);
    #1;
    check("first_csn", 32'(csn), 32'd0);
    check("first_mo", 32'(mo), 32'd1);
    wait_wb(1, 400, "tmo_frame0");
    #2 rstn = 1'b0;

    repeat (2) @(negedge clk);
    model[0] = 24'hABCDEF;
    dut.ram_inst.mem[0] = 24'hABCDEF;
    rstn = 1'b1;
    hit = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (in_frame && nrise >= 10) begin
        hit = 1;
        break;
      end
    end
    check("tmo_rise10", 32'(hit), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("abort_csn", 32'(csn), 32'd1);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_mo", 32'(mo), 32'd0);
    repeat (2) @(negedge clk);
    check("no_partial_wb", 32'(dut.ram_inst.mem[0]), 32'h00ABCDEF);

    rx0 = 24'h123456;
    base_wb = nwb;
    rstn = 1'b1;
    wait_wb(base_wb + 1, 400, "tmo_restart");
    check("mem0_rx", 32'(dut.ram_inst.mem[0]), 32'h00123456);
    wait_wb(base_wb + DEPTH, DEPTH * 130, "tmo_all");
    base_fr = nframes;
`ifdef SPI_MASTER_LOOP_EN
    wait_wb(base_wb + DEPTH + 1, 400, "tmo_wrap");
    check("wrap_tx", 32'(last_tx), 32'h00123456);
`else
    repeat (300) @(negedge clk);
    check("done_csn", 32'(csn), 32'd1);
    check("done_sck", 32'(sck), 32'd0);
    check("done_mo", 32'(mo), 32'd0);
    check("done_frames", 32'(nframes), 32'(base_fr));
`endif
    check("mo_idle", 32'(idle_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end
endmodule
